keypad_reader: RTL and testbench
================================

# keypad_reader

Reader side of the 4x4 keypad scan interface. Samples the keypad row inputs together with the column drive from the column sequencer, then synchronizes, debounces and decodes the active key to a 4-bit hex code. Emits a single-cycle press strobe and a held key-down level for the display and tone-selection logic downstream.

## Interface
- DEBOUNCE_CYCLES, 16 — consecutive matching samples needed after first detection to accept a press or release; legal range 2..65535; counter width $clog2(DEBOUNCE_CYCLES+1).
- clk  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- kpr  input  4  keypad rows, active-low, asynchronous to clk.
- kpc  input  4  column drive from the column sequencer, one-hot-low, synchronous to clk.
- key_code  output  4  hex code of the last accepted key; held until the next accepted press.
- key_valid  output  1  one-cycle pulse when a press is accepted; key_code is valid in the same cycle.
- key_down  output  1  high from press acceptance until release acceptance.

## Operation
- Input stage:
  - kpr passes through a 2-FF synchronizer (kpr_s).
  - kpc passes through a matching 2-stage delay (kpc_s) so row and column stay aligned.
  - All four registers reset to 4'b1111.
- Key present: kpr_s has exactly one 0 bit and kpc_s has exactly one 0 bit. Any other pattern (multiple rows, multiple columns, all ones) means no key.
- Row/column index: 0111→0, 1011→1, 1101→2, 1110→3.
- Decode (row,col): code = layout[row][col].
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E(*) 0 F(#) D
- FSM states: IDLE, DB_PRESS, PRESSED, DB_RELEASE. Counter cnt.
  - IDLE: if a key is present, capture cand=code, cnt←0, go to DB_PRESS.
  - DB_PRESS:
    - Key present and code==cand: if cnt==DEBOUNCE_CYCLES-1, go to PRESSED, key_code←cand, key_valid←1, key_down←1; otherwise cnt++.
    - Any mismatch or no key: go to IDLE without producing output.
  - PRESSED:
    - kpr_s==4'b1111: cnt←0, go to DB_RELEASE.
    - Any other pattern, including a different key or multiple keys, is ignored: no new strobe, key_code unchanged.
  - DB_RELEASE:
    - kpr_s==4'b1111: if cnt==DEBOUNCE_CYCLES-1, go to IDLE and set key_down←0; otherwise cnt++.
    - Any row low: go back to PRESSED; key_down stays 1.
- key_valid is registered and deasserts on the next cycle.
- Reset:
  - Values: state=IDLE, cnt=0, cand=0, key_code=0, key_valid=0, key_down=0, synchronizers=4'b1111.
  - An asynchronous reset mid-press drops key_down immediately.
  - After reset, a key still held down must debounce again and produces a fresh key_valid.

## Timing
- Edge 0 is the first rising edge that samples a new stable kpr.
  - kpr_s is valid after edge 1.
  - The FSM leaves IDLE at edge 2.
  - key_valid and key_down rise at edge DEBOUNCE_CYCLES+2, after DEBOUNCE_CYCLES+1 matching samples.
- Release: with kpr returning to 1111 at edge R, key_down falls at edge R+DEBOUNCE_CYCLES+2.
- Bounce: a single non-matching sample restarts the debounce. On press this means returning to IDLE, so the new detection is at least one cycle later. On release it means returning to PRESSED.
- Minimum press-to-press interval: 2·(DEBOUNCE_CYCLES+2) cycles of clean input.
- kpc must stay frozen while a row is low, which the column sequencer guarantees. If kpc_s changes during DB_PRESS, that counts as a mismatch.

## Test plan
- Reset, DEBOUNCE_CYCLES=4, drive kpr=4'b1111 -> all outputs 0 and remain 0 for 50 cycles.
- kpc=4'b1011, kpr=4'b1101 held 20 cycles -> key_valid pulses exactly once at edge 6 with key_code=4'h8; key_down=1 from edge 6 on.
- Release kpr=4'b1111 at edge R -> key_down falls at edge R+6; then press kpc=4'b1110, kpr=4'b1110 -> key_code=4'hD, single pulse.
- Bounce: kpr toggles 1101/1111 every 2 cycles for 20 cycles, then holds 1101 -> no key_valid during toggling; exactly one pulse 6 edges after the stable hold begins.
- Two rows low (kpr=4'b0101) or kpc=4'b0011 -> no key_valid; key_code keeps its prior value.
- Assert reset while key_down=1 -> key_down, key_valid and key_code go to 0 immediately; with the key still held after reset deasserts, a new pulse arrives 6 edges later.

Source files
------------

// File: rtl/keypad_reader.sv
// Reader side of the 4x4 keypad scan: synchronizes rows, aligns the column drive,
// debounces the active key and reports it as a hex code with press strobe and held level.
module keypad_reader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr,
  input  logic [3:0] kpc,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [3:0]      cand_reg;
  logic [3:0]      kpr_meta_reg;
  logic [3:0]      kpr_s;
  logic [3:0]      kpc_dly_reg;
  logic [3:0]      kpc_s;
  logic            key_present;
  logic [3:0]      code;

  // Column drive is delayed by the same two stages as the row synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kpr_meta_reg <= 4'b1111;
      kpr_s        <= 4'b1111;
      kpc_dly_reg  <= 4'b1111;
      kpc_s        <= 4'b1111;
    end else begin
      kpr_meta_reg <= kpr;
      kpr_s        <= kpr_meta_reg;
      kpc_dly_reg  <= kpc;
      kpc_s        <= kpc_dly_reg;
    end
  end

  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    case (v)
      4'b0111: low_index = 2'd0;
      4'b1011: low_index = 2'd1;
      4'b1101: low_index = 2'd2;
      default: low_index = 2'd3;
    endcase
  endfunction

  always_comb begin
    key_present = one_low(kpr_s) && one_low(kpc_s);
    code        = 4'h0;
    case ({low_index(kpr_s), low_index(kpc_s)})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      cand_reg  <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (key_present) begin
            cand_reg  <= code;
            cnt_reg   <= '0;
            state_reg <= DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (key_present && code == cand_reg) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= PRESSED;
              key_code  <= cand_reg;
              key_valid <= 1'b1;
              key_down  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        PRESSED: begin
          // Other keys or chords while held are deliberately ignored
          if (kpr_s == 4'b1111) begin
            cnt_reg   <= '0;
            state_reg <= DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (kpr_s == 4'b1111) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= IDLE;
              key_down  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end else begin
            state_reg <= PRESSED;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_reader.sv
// Directed bench for keypad_reader: run-length press/release model checked every cycle,
// plus hand-computed pulse timing and code expectations.
module tb_keypad_reader;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] kpr = 4'b1111;
  logic [3:0] kpc = 4'b1111;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_count = 0;
  int last_valid_cyc = -1;
  int down_fall_cyc = -1;

  // Model state: press/release expressed as run lengths of qualifying samples
  logic       m_pressed = 1'b0;
  int         m_run = 0;
  logic [3:0] m_cand = 4'h0;
  logic [3:0] m_code = 4'h0;
  logic       m_valid = 1'b0;
  logic [3:0] hr [3];
  logic [3:0] hc [3];
  logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  keypad_reader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .kpr(kpr), .kpc(kpc),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int zero_pos(input logic [3:0] v);
    int n = 0;
    int p = -1;
    for (int i = 0; i < 4; i++) begin
      if (!v[3-i]) begin
        n++;
        p = i;
      end
    end
    return (n == 1) ? p : -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic [3:0] c);
    int  ri = zero_pos(r);
    int  ci = zero_pos(c);
    bit  pres = (ri >= 0) && (ci >= 0);
    logic [3:0] k = pres ? layout[ri*4 + ci] : 4'h0;
    m_valid = 1'b0;
    if (!m_pressed) begin
      if (m_run == 0) begin
        if (pres) begin
          m_cand = k;
          m_run  = 1;
        end
      end else if (pres && k == m_cand) begin
        m_run++;
        if (m_run == D + 1) begin
          m_pressed = 1'b1;
          m_valid   = 1'b1;
          m_code    = m_cand;
          m_run     = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (r == 4'b1111) begin
        m_run++;
        if (m_run == D + 1) begin
          m_pressed = 1'b0;
          m_run     = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // Compare process: the FSM at edge n acts on inputs seen three negedges earlier
  initial begin
    logic prev_down = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_pressed = 1'b0; m_run = 0; m_cand = 4'h0; m_code = 4'h0; m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
          hr[i] = 4'b1111;
          hc[i] = 4'b1111;
        end
      end else begin
        model_step(hr[2], hc[2]);
        hr[2] = hr[1]; hc[2] = hc[1];
        hr[1] = hr[0]; hc[1] = hc[0];
        hr[0] = kpr;   hc[0] = kpc;
      end
      chk("key_valid", int'(key_valid), int'(m_valid));
      chk("key_down", int'(key_down), int'(m_pressed));
      chk("key_code", int'(key_code), int'(m_code));
      if (key_valid) begin
        valid_count++;
        last_valid_cyc = cyc;
      end
      if (prev_down && !key_down) down_fall_cyc = cyc;
      prev_down = key_down;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] c);
    kpr = r;
    kpc = c;
  endtask

  initial begin
    int e0;
    int vc0;
    step(3);
    reset = 1'b0;
    chk("reset_down", int'(key_down), 0);
    chk("reset_code", int'(key_code), 0);
    step(50);
    chk("idle_no_pulse", valid_count, 0);

    drive(4'b1101, 4'b1011);
    e0 = cyc + 1; vc0 = valid_count;
    step(20);
    chk("press8_count", valid_count - vc0, 1);
    chk("press8_edge", last_valid_cyc - e0, 6);
    chk("press8_code", int'(key_code), 8);
    chk("press8_down", int'(key_down), 1);

    drive(4'b1111, 4'b1011);
    e0 = cyc + 1;
    step(10);
    chk("release_edge", down_fall_cyc - e0, 6);
    drive(4'b1110, 4'b1110);
    vc0 = valid_count;
    step(12);
    chk("pressD_count", valid_count - vc0, 1);
    chk("pressD_code", int'(key_code), 13);
    drive(4'b1111, 4'b1110);
    step(10);

    vc0 = valid_count;
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 4'b1101 : 4'b1111, 4'b1011);
      step(2);
    end
    chk("bounce_no_pulse", valid_count - vc0, 0);
    drive(4'b1101, 4'b1011);
    e0 = cyc + 1;
    step(14);
    chk("bounce_count", valid_count - vc0, 1);
    chk("bounce_edge", last_valid_cyc - e0, 6);
    drive(4'b1111, 4'b1011);
    step(10);

    vc0 = valid_count;
    drive(4'b0101, 4'b1011);
    step(15);
    drive(4'b1111, 4'b1011);
    step(4);
    drive(4'b1101, 4'b0011);
    step(15);
    chk("multi_no_pulse", valid_count - vc0, 0);
    chk("multi_code_kept", int'(key_code), 8);
    drive(4'b1111, 4'b1111);
    step(6);

    drive(4'b0111, 4'b0111);
    vc0 = valid_count;
    step(12);
    chk("press1_code", int'(key_code), 1);
    drive(4'b0011, 4'b0111);
    step(8);
    chk("held_chord_ignored", valid_count - vc0, 1);
    chk("held_chord_code", int'(key_code), 1);
    drive(4'b1111, 4'b0111);
    step(2);
    drive(4'b0111, 4'b0111);
    step(1);
    drive(4'b1111, 4'b0111);
    step(12);
    chk("release_bounce_down", int'(key_down), 0);
    chk("release_bounce_count", valid_count - vc0, 1);

    drive(4'b1011, 4'b1101);
    step(12);
    chk("press6_code", int'(key_code), 6);
    chk("press6_down", int'(key_down), 1);
    reset = 1'b1;
    #1;
    chk("async_down", int'(key_down), 0);
    chk("async_valid", int'(key_valid), 0);
    chk("async_code", int'(key_code), 0);
    step(2);
    reset = 1'b0;
    e0 = cyc + 1; vc0 = valid_count;
    step(12);
    chk("repress_count", valid_count - vc0, 1);
    chk("repress_edge", last_valid_cyc - e0, 6);
    chk("repress_code", int'(key_code), 6);
    drive(4'b1111, 4'b1101);
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
